// File: rtl/xc_pkg.sv
// Shared encodings for the register-transfer sequencer: command opcodes,
// sequencer states and register-file index names.
package xc_pkg;

    typedef enum logic [1:0] {
        OP_MOV   = 2'b00,
        OP_LDI   = 2'b01,
        OP_SWAP  = 2'b10,
        OP_INCFG = 2'b11
    } xc_op_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_B = 3'd2,
        ST_WR_A = 3'd3,
        ST_WR_B = 3'd4,
        ST_FIN  = 3'd5
    } xc_state_e;

    localparam int unsigned REG_ACC     = 0;
    localparam int unsigned REG_B       = 1;
    localparam int unsigned REG_C       = 2;
    localparam int unsigned REG_D       = 3;
    localparam int unsigned REG_E       = 4;
    localparam int unsigned REG_F       = 5;
    localparam int unsigned REG_G       = 6;
    localparam int unsigned REG_ILLEGAL = 7;

endpackage

// File: rtl/rf_xfer_ctrl.sv
// Command-driven register-file transfer sequencer (MOV/LDI/SWAP/INCFG).
// Define XC_ACC_GUARD_EN to reject commands that would write the accumulator.
module rf_xfer_ctrl
    import xc_pkg::*;
#(
    parameter int DW = 8,
    parameter int RW = 3
) (
    input  logic          XC_clk,
    input  logic          XC_rst_n,
    input  logic          XC_cmd_valid,
    output logic          XC_cmd_ready,
    input  logic [1:0]    XC_cmd_op,
    input  logic [RW-1:0] XC_cmd_src,
    input  logic [RW-1:0] XC_cmd_dst,
    input  logic [DW-1:0] XC_cmd_imm,
    output logic [RW-1:0] XC_rf_sel,
    output logic [DW-1:0] XC_rf_din,
    output logic          XC_rf_we,
    input  logic [DW-1:0] XC_rf_dout,
    output logic          XC_acc_hold,
    output logic          XC_done,
    output logic          XC_err
);

    xc_state_e     r_state;
    xc_state_e     w_next;
    xc_op_e        r_op;
    xc_op_e        w_op;
    logic [RW-1:0] r_src;
    logic [RW-1:0] r_dst;
    logic [DW-1:0] r_imm;
    logic [DW-1:0] r_tmp_a;
    logic [DW-1:0] r_tmp_b;
    logic          r_carry;
    logic          r_err;
    logic          w_accept;
    logic          w_illegal;
    logic          w_src_bad;
    logic          w_dst_bad;
    logic          w_src_acc;
    logic          w_dst_acc;

    assign w_op      = xc_op_e'(XC_cmd_op);
    assign w_accept  = XC_cmd_valid && (r_state == ST_IDLE);
    assign w_src_bad = (XC_cmd_src == RW'(REG_ILLEGAL));
    assign w_dst_bad = (XC_cmd_dst == RW'(REG_ILLEGAL));

`ifdef XC_ACC_GUARD_EN
    assign w_src_acc = (XC_cmd_src == RW'(REG_ACC));
    assign w_dst_acc = (XC_cmd_dst == RW'(REG_ACC));
`else
    assign w_src_acc = 1'b0;
    assign w_dst_acc = 1'b0;
`endif

    // SWAP writes both of its indices, so either one hitting Acc counts as an Acc write.
    always_comb begin
        w_illegal = 1'b0;
        case (w_op)
            OP_MOV:  w_illegal = w_src_bad | w_dst_bad | w_dst_acc;
            OP_LDI:  w_illegal = w_dst_bad | w_dst_acc;
            OP_SWAP: w_illegal = w_src_bad | w_dst_bad | w_src_acc | w_dst_acc;
            default: w_illegal = 1'b0;
        endcase
    end

    always_ff @(posedge XC_clk or negedge XC_rst_n) begin
        if (!XC_rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    if (w_illegal) begin
                        w_next = ST_FIN;
                    end else if (w_op == OP_LDI) begin
                        w_next = ST_WR_A;
                    end else begin
                        w_next = ST_RD_A;
                    end
                end
            end
            ST_RD_A: w_next = (r_op == OP_MOV) ? ST_WR_A : ST_RD_B;
            ST_RD_B: w_next = ST_WR_A;
            ST_WR_A: w_next = (r_op == OP_MOV || r_op == OP_LDI) ? ST_FIN : ST_WR_B;
            ST_WR_B: w_next = ST_FIN;
            ST_FIN:  w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // INCFG is a SWAP-shaped read of G then F; forcing the indices here keeps the read path uniform.
    always_ff @(posedge XC_clk or negedge XC_rst_n) begin
        if (!XC_rst_n) begin
            r_op    <= OP_MOV;
            r_src   <= '0;
            r_dst   <= '0;
            r_imm   <= '0;
            r_tmp_a <= '0;
            r_tmp_b <= '0;
            r_carry <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op  <= w_op;
                        r_imm <= XC_cmd_imm;
                        r_err <= w_illegal;
                        if (w_op == OP_INCFG) begin
                            r_src <= RW'(REG_G);
                            r_dst <= RW'(REG_F);
                        end else begin
                            r_src <= XC_cmd_src;
                            r_dst <= XC_cmd_dst;
                        end
                    end
                end
                ST_RD_A: r_tmp_a <= XC_rf_dout;
                ST_RD_B: r_tmp_b <= XC_rf_dout;
                ST_WR_A: r_carry <= (r_tmp_a == '1);
                default: ;
            endcase
        end
    end

    always_comb begin
        XC_rf_sel = '0;
        XC_rf_din = '0;
        XC_rf_we  = 1'b0;
        case (r_state)
            ST_RD_A: XC_rf_sel = r_src;
            ST_RD_B: XC_rf_sel = r_dst;
            ST_WR_A: begin
                XC_rf_we = 1'b1;
                case (r_op)
                    OP_INCFG: begin
                        XC_rf_sel = RW'(REG_G);
                        XC_rf_din = r_tmp_a + DW'(1);
                    end
                    OP_LDI: begin
                        XC_rf_sel = r_dst;
                        XC_rf_din = r_imm;
                    end
                    default: begin
                        XC_rf_sel = r_dst;
                        XC_rf_din = r_tmp_a;
                    end
                endcase
            end
            ST_WR_B: begin
                XC_rf_we = 1'b1;
                if (r_op == OP_INCFG) begin
                    XC_rf_sel = RW'(REG_F);
                    XC_rf_din = r_tmp_b + DW'(r_carry);
                end else begin
                    XC_rf_sel = r_src;
                    XC_rf_din = r_tmp_b;
                end
            end
            default: ;
        endcase
    end

    assign XC_cmd_ready = (r_state == ST_IDLE);
    assign XC_acc_hold  = (r_state != ST_IDLE);
    assign XC_done      = (r_state == ST_FIN);
    assign XC_err       = (r_state == ST_FIN) && r_err;

endmodule

// File: tb/tb_rf_xfer_ctrl.sv
// Self-checking bench for rf_xfer_ctrl: directed vector table, randomized commands
// against a behavioural model, and a reset-during-SWAP sequence.
module tb_rf_xfer_ctrl;

    localparam logic [1:0] C_MOV   = 2'b00;
    localparam logic [1:0] C_LDI   = 2'b01;
    localparam logic [1:0] C_SWAP  = 2'b10;
    localparam logic [1:0] C_INCFG = 2'b11;

`ifdef XC_ACC_GUARD_EN
    localparam bit GUARD = 1'b1;
`else
    localparam bit GUARD = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       valid;
    logic       ready;
    logic [1:0] op;
    logic [2:0] src;
    logic [2:0] dst;
    logic [7:0] imm;
    logic [2:0] sel;
    logic [7:0] din;
    logic       we;
    logic [7:0] dout;
    logic       hold;
    logic       done;
    logic       err;

    logic [7:0]  rf [8];
    logic [7:0]  expRf [8];
    logic [10:0] gotWr [$];
    logic [10:0] expWr [$];
    int nVec = 0;
    int nBad = 0;

    typedef struct {
        logic [1:0] op;
        logic [2:0] src;
        logic [2:0] dst;
        logic [7:0] imm;
        int         expLat;
        bit         expErr;
    } vec_t;

    vec_t tbl [14];

    always #5 clk = ~clk;

    rf_xfer_ctrl #(.DW(8), .RW(3)) dut (
        .XC_clk       (clk),
        .XC_rst_n     (rst_n),
        .XC_cmd_valid (valid),
        .XC_cmd_ready (ready),
        .XC_cmd_op    (op),
        .XC_cmd_src   (src),
        .XC_cmd_dst   (dst),
        .XC_cmd_imm   (imm),
        .XC_rf_sel    (sel),
        .XC_rf_din    (din),
        .XC_rf_we     (we),
        .XC_rf_dout   (dout),
        .XC_acc_hold  (hold),
        .XC_done      (done),
        .XC_err       (err)
    );

    // Behavioural register file with combinational read; also logs every write.
    assign dout = rf[sel];
    always @(posedge clk) begin
        if (we === 1'b1) begin
            rf[sel] <= din;
            gotWr.push_back({sel, din});
        end
    end

    task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] expv);
        nVec++;
        if (act !== expv) begin
            nBad++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, expv);
        end
    endtask

    // Reference model: command semantics on a register array, plus expected write list.
    task automatic modelCmd(input logic [1:0] mop, input logic [2:0] msrc, input logic [2:0] mdst,
                            input logic [7:0] mimm, output int lat, output bit merr);
        logic [7:0]  a;
        logic [7:0]  b;
        logic [15:0] fg;
        expWr.delete();
        case (mop)
            C_MOV:   merr = (msrc == 7) || (mdst == 7) || (GUARD && mdst == 0);
            C_LDI:   merr = (mdst == 7) || (GUARD && mdst == 0);
            C_SWAP:  merr = (msrc == 7) || (mdst == 7) || (GUARD && (msrc == 0 || mdst == 0));
            default: merr = 1'b0;
        endcase
        if (merr) begin
            lat = 1;
        end else begin
            case (mop)
                C_MOV: begin
                    expWr.push_back({mdst, expRf[msrc]});
                    expRf[mdst] = expRf[msrc];
                    lat = 3;
                end
                C_LDI: begin
                    expWr.push_back({mdst, mimm});
                    expRf[mdst] = mimm;
                    lat = 2;
                end
                C_SWAP: begin
                    a = expRf[msrc];
                    b = expRf[mdst];
                    expWr.push_back({mdst, a});
                    expWr.push_back({msrc, b});
                    expRf[mdst] = a;
                    expRf[msrc] = b;
                    lat = 5;
                end
                default: begin
                    fg = {expRf[5], expRf[6]} + 16'd1;
                    expWr.push_back({3'd6, fg[7:0]});
                    expWr.push_back({3'd5, fg[15:8]});
                    expRf[6] = fg[7:0];
                    expRf[5] = fg[15:8];
                    lat = 5;
                end
            endcase
        end
    endtask

    task automatic waitReady();
        int cnt = 0;
        @(negedge clk);
        while (ready !== 1'b1 && cnt < 50) begin
            @(negedge clk);
            cnt++;
        end
        checkVal("ready_before_cmd", ready, 1);
    endtask

    task automatic applyStimulus(input logic [1:0] aop, input logic [2:0] asrc, input logic [2:0] adst,
                                 input logic [7:0] aimm, output int lat, output bit errSeen);
        waitReady();
        gotWr.delete();
        valid = 1'b1;
        op    = aop;
        src   = asrc;
        dst   = adst;
        imm   = aimm;
        @(posedge clk);
        #1 valid = 1'b0;
        lat     = -1;
        errSeen = 1'b0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            checkVal("acc_hold_busy", hold, 1);
            if (done === 1'b1) begin
                lat     = k;
                errSeen = err;
                break;
            end
        end
        @(negedge clk);
        checkVal("done_one_cycle", done, 0);
        checkVal("ready_after_done", ready, 1);
    endtask

    task automatic checkOutput(input string tag, input int lat, input bit errSeen,
                               input int expLat, input bit expErr);
        int n;
        checkVal({tag, "_latency"}, lat, expLat);
        checkVal({tag, "_err"}, errSeen, expErr);
        checkVal({tag, "_nwrites"}, gotWr.size(), expWr.size());
        n = (gotWr.size() < expWr.size()) ? gotWr.size() : expWr.size();
        for (int i = 0; i < n; i++) checkVal({tag, "_write"}, gotWr[i], expWr[i]);
        for (int r = 0; r < 8; r++) checkVal({tag, "_reg"}, {r[7:0], rf[r]}, {r[7:0], expRf[r]});
    endtask

    initial begin
        int  lat;
        int  mLat;
        bit  errSeen;
        bit  mErr;
        bit  sawDone;
        logic [1:0] rop;
        logic [2:0] rsrc;
        logic [2:0] rdst;
        logic [7:0] rimm;

        for (int r = 0; r < 8; r++) begin
            rf[r]    = 8'h00;
            expRf[r] = 8'h00;
        end
        rf[0] = 8'h49; rf[1] = 8'h06; rf[2] = 8'h06;
        expRf[0] = 8'h49; expRf[1] = 8'h06; expRf[2] = 8'h06;

        tbl[0]  = '{C_LDI,   3'd0, 3'd3, 8'hA5, 2, 1'b0};
        tbl[1]  = '{C_MOV,   3'd0, 3'd4, 8'h00, 3, 1'b0};
        tbl[2]  = '{C_LDI,   3'd0, 3'd1, 8'h12, 2, 1'b0};
        tbl[3]  = '{C_SWAP,  3'd1, 3'd0, 8'h00, GUARD ? 1 : 5, GUARD};
        tbl[4]  = '{C_LDI,   3'd0, 3'd5, 8'h12, 2, 1'b0};
        tbl[5]  = '{C_LDI,   3'd0, 3'd6, 8'hFF, 2, 1'b0};
        tbl[6]  = '{C_INCFG, 3'd0, 3'd0, 8'h00, 5, 1'b0};
        tbl[7]  = '{C_LDI,   3'd0, 3'd5, 8'hFF, 2, 1'b0};
        tbl[8]  = '{C_LDI,   3'd0, 3'd6, 8'hFF, 2, 1'b0};
        tbl[9]  = '{C_INCFG, 3'd7, 3'd7, 8'h00, 5, 1'b0};
        tbl[10] = '{C_MOV,   3'd7, 3'd2, 8'h00, 1, 1'b1};
        tbl[11] = '{C_SWAP,  3'd2, 3'd2, 8'h00, 5, 1'b0};
        tbl[12] = '{C_MOV,   3'd3, 3'd3, 8'h00, 3, 1'b0};
        tbl[13] = '{C_LDI,   3'd0, 3'd0, 8'h77, GUARD ? 1 : 2, GUARD};

        valid = 1'b0; op = '0; src = '0; dst = '0; imm = '0;
        rst_n = 1'b0;
        #1;
        checkVal("rst_ready", ready, 1);
        checkVal("rst_we", we, 0);
        checkVal("rst_sel", sel, 0);
        checkVal("rst_din", din, 0);
        checkVal("rst_hold", hold, 0);
        checkVal("rst_done", done, 0);
        checkVal("rst_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 14; i++) begin
            modelCmd(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].imm, mLat, mErr);
            applyStimulus(tbl[i].op, tbl[i].src, tbl[i].dst, tbl[i].imm, lat, errSeen);
            checkOutput($sformatf("vec%0d", i), lat, errSeen, tbl[i].expLat, tbl[i].expErr);
        end

        for (int i = 0; i < 60; i++) begin
            rop  = 2'($urandom_range(0, 3));
            rsrc = 3'($urandom_range(0, 7));
            rdst = 3'($urandom_range(0, 7));
            rimm = 8'($urandom);
            modelCmd(rop, rsrc, rdst, rimm, mLat, mErr);
            applyStimulus(rop, rsrc, rdst, rimm, lat, errSeen);
            checkOutput($sformatf("rnd%0d", i), lat, errSeen, mLat, mErr);
        end

        // Reset during WR_B of a SWAP: the WR_A write stays, WR_B and done never happen.
        modelCmd(C_LDI, 3'd0, 3'd2, 8'h3C, mLat, mErr);
        applyStimulus(C_LDI, 3'd0, 3'd2, 8'h3C, lat, errSeen);
        checkOutput("pre_rst", lat, errSeen, 2, 1'b0);
        modelCmd(C_LDI, 3'd0, 3'd3, 8'hC3, mLat, mErr);
        applyStimulus(C_LDI, 3'd0, 3'd3, 8'hC3, lat, errSeen);
        checkOutput("pre_rst2", lat, errSeen, 2, 1'b0);

        waitReady();
        gotWr.delete();
        expWr.delete();
        expWr.push_back({3'd3, expRf[2]});
        expRf[3] = expRf[2];
        valid = 1'b1; op = C_SWAP; src = 3'd2; dst = 3'd3; imm = 8'h00;
        @(posedge clk);
        #1 valid = 1'b0;
        repeat (4) @(negedge clk);
        checkVal("wrb_we", we, 1);
        checkVal("wrb_sel", sel, 2);
        rst_n = 1'b0;
        #1;
        checkVal("midrst_we", we, 0);
        checkVal("midrst_ready", ready, 1);
        checkVal("midrst_hold", hold, 0);
        sawDone = 1'b0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) sawDone = 1'b1;
        end
        rst_n = 1'b1;
        repeat (5) begin
            @(negedge clk);
            if (done === 1'b1) sawDone = 1'b1;
        end
        checkVal("midrst_no_done", sawDone, 0);
        checkVal("midrst_ready_after", ready, 1);
        checkOutput("midrst", 5, 1'b0, 5, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nBad);
        $finish;
    end

endmodule

// File: doc/rf_xfer_ctrl.md
Name: rf_xfer_ctrl

Overview:
Command-driven register-transfer sequencer that drives the register file's Select/Data_in/RF_we port and consumes its Data_out. It accepts one command at a time: MOV, LDI, SWAP or INCFG (16-bit increment of the F:G pointer pair). Each command is expanded into a fixed sequence of read and write cycles. It sits between the instruction decoder and the register file; while busy it asks the ALU path to hold off accumulator writes.

Parameters:
DW, 8, register data width
RW, 3, register select width (index 7 is illegal)

Ports:
XC_clk  in  1  rising-edge clock, same clock as the register file
XC_rst_n  in  1  asynchronous active-low reset
XC_cmd_valid  in  1  command present
XC_cmd_ready  out  1  controller idle; command accepted when valid&&ready
XC_cmd_op  in  2  00 MOV, 01 LDI, 10 SWAP, 11 INCFG
XC_cmd_src  in  RW  source register index (MOV/SWAP)
XC_cmd_dst  in  RW  destination register index (MOV/LDI/SWAP)
XC_cmd_imm  in  DW  immediate (LDI)
XC_rf_sel  out  RW  to register file Select
XC_rf_din  out  DW  to register file Data_in
XC_rf_we  out  1  to register file RF_we
XC_rf_dout  in  DW  from register file Data_out (combinational read)
XC_acc_hold  out  1  high whenever not IDLE; gates external Acc_we
XC_done  out  1  one-cycle pulse on command completion
XC_err  out  1  one-cycle pulse with XC_done on an illegal command

Behaviour:
- Reset values (asynchronous, immediate on XC_rst_n low): state IDLE, XC_cmd_ready=1, XC_rf_we=0, XC_rf_sel=0, XC_rf_din=0, XC_acc_hold=0, XC_done=0, XC_err=0, temporaries 0.
- States: IDLE, RD_A, RD_B, WR_A, WR_B, FIN.
- Accept: in IDLE, on valid&&ready, latch op/src/dst/imm.
  - MOV -> RD_A. LDI -> WR_A. SWAP -> RD_A. INCFG -> RD_A with src forced to 6 (G) and dst forced to 5 (F).
- RD_A: sel=src, we=0; tmp_a<=XC_rf_dout at the clock edge. Next state: RD_B for SWAP/INCFG, WR_A for MOV.
- RD_B: sel=dst, we=0; tmp_b<=XC_rf_dout. Next state: WR_A.
- WR_A: we=1. Next state: FIN for MOV/LDI, WR_B for SWAP/INCFG.
  - MOV: sel=dst, din=tmp_a.
  - LDI: sel=dst, din=imm.
  - SWAP: sel=dst, din=tmp_a.
  - INCFG: sel=6, din=tmp_a+1 (8-bit wrap); carry=(tmp_a==8'hFF) is registered.
- WR_B: we=1. Next state: FIN.
  - SWAP: sel=src, din=tmp_b.
  - INCFG: sel=5, din=tmp_b+carry (8-bit wrap, so FFFF -> 0000).
- FIN: done=1, we=0, next state IDLE.
- Latency from accept edge to done cycle: MOV 3, LDI 2, SWAP 5, INCFG 5. Minimum issue interval is latency+1.
- XC_cmd_ready=1 only in IDLE; commands are never queued.
- Illegal command (any used index ==7): go directly to FIN with err=1 and done=1; no RF write occurs.
- SWAP with src==dst: runs normally; the register value is unchanged.
- MOV with src==dst: runs normally; the register is rewritten with its own value.
- Outputs are Moore, decoded from state plus latched fields. XC_rf_we is never high outside WR_A/WR_B.
- Reset mid-command: sequence aborted, no further writes, no done pulse. A write committed on an earlier edge stays committed.

Optional Feature:
XC_ACC_GUARD_EN
- Defined: a command whose write target is index 0 (Acc) is illegal, handled like index 7 (err+done, no write). Reading Acc as a source stays legal.
- Undefined: Acc is a legal destination like any other register.

Decomposition:
- Shared package xc_pkg holds:
  - op encodings OP_MOV/OP_LDI/OP_SWAP/OP_INCFG
  - state enum
  - register index constants REG_ACC=0 … REG_G=6, REG_ILLEGAL=7
- No sub-module; the 8-bit increment-with-carry is inline.

Test Plan:
- Bench uses a behavioural register file model (Acc=49, B=06, C=06 at start) and checks write traffic and register contents.
- LDI dst=3 imm=A5 -> single write sel=3 din=A5; done 2 cycles after accept; D=A5.
- MOV src=0 dst=4 -> exactly one write, sel=4 din=49; E=49; done 3 cycles after accept.
- SWAP src=1 dst=0 after B=12 -> writes Acc=12 then B=49; done at cycle 5; acc_hold high throughout.
- INCFG with F=12, G=FF -> G=00 then F=13. Second case F=FF, G=FF -> both 00.
- MOV src=7 -> err+done pulse, zero writes. With XC_ACC_GUARD_EN, LDI dst=0 -> err, Acc stays 49.
- Assert XC_rst_n low during SWAP after WR_A -> we drops immediately, no WR_B, no done, ready=1 after release.
